// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths and fetch FSM state encoding
package cpu_pkg;
  localparam int INS_W     = 19;
  localparam int ADDR_W    = 14;
  localparam int OPCODE_W  = 5;
  localparam int RAS_DEPTH = 8;
  typedef enum logic [1:0] {FETCH = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} fetch_state_e;
endpackage

// File: rtl/fetch_ras.sv
// fetch_ras: circular return-address stack; a push when full overwrites the oldest entry
module fetch_ras
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW:0] r_cnt;
  logic [PW-1:0] w_top_idx;
  logic w_has;
  assign w_top_idx = r_ptr - 1'b1;
  assign w_has = r_cnt != '0;
  assign empty = ~w_has;
  assign top = w_has ? r_mem[w_top_idx] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (push & pop & w_has) begin
      r_mem[w_top_idx] <= din;
    end else if (push) begin
      r_mem[r_ptr] <= din;
      r_ptr <= r_ptr + 1'b1;
      if (r_cnt != (PW+1)'(RAS_DEPTH)) r_cnt <= r_cnt + 1'b1;
    end else if (pop & w_has) begin
      r_ptr <= r_ptr - 1'b1;
      r_cnt <= r_cnt - 1'b1;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM (FETCH/DRAIN/HOLD) feeding the IR.
// Define FETCH_RAS_EN to build in the 8-entry return-address stack.
module fetch_unit
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [INS_W-1:0]  mem_rdata,
  output logic [INS_W-1:0]  ins,
  output logic              load_IR,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ras_push,
  input  logic              ras_pop,
  output logic [ADDR_W-1:0] ras_top,
  output logic              ras_empty
);
  fetch_state_e r_state;
  logic [ADDR_W-1:0] r_pc, r_ins_pc;
  logic [INS_W-1:0] r_ins;
  logic r_load;
  logic w_fetch, w_drain, w_hold;
  assign w_fetch = r_state == FETCH;
  assign w_drain = r_state == DRAIN;
  assign w_hold = r_state == HOLD;
  assign mem_req = w_fetch;
  assign mem_addr = r_pc;
  assign ins = r_ins;
  assign ins_pc = r_ins_pc;
  // a redirect in the load cycle means the word on ins is wrong-path
  assign load_IR = ~rst & ~redirect_valid & (r_load | (w_hold & ~stall));
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc <= '0;
      r_ins <= '0;
      r_ins_pc <= '0;
      r_load <= 1'b0;
    end else begin
      r_load <= w_fetch & mem_ack & ~redirect_valid & ~stall;
      if (redirect_valid) begin
        r_pc <= redirect_addr;
        r_state <= (~w_hold & ~mem_ack) ? DRAIN : FETCH;
      end else if (w_fetch & mem_ack) begin
        r_ins <= mem_rdata;
        r_ins_pc <= r_pc;
        r_pc <= r_pc + 1'b1;
        r_state <= stall ? HOLD : FETCH;
      end else if ((w_drain & mem_ack) | (w_hold & ~stall)) begin
        r_state <= FETCH;
      end
    end
  end
`ifdef FETCH_RAS_EN
  logic [ADDR_W-1:0] w_ret;
  assign w_ret = r_ins_pc + 1'b1;
  fetch_ras u_ras (
    .clk(clk), .rst(rst), .push(ras_push), .pop(ras_pop),
    .din(w_ret), .top(ras_top), .empty(ras_empty)
  );
`else
  logic w_unused;
  assign w_unused = ras_push ^ ras_pop;
  assign ras_top = '0;
  assign ras_empty = 1'b1;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors; loaded words are scoreboarded against a queue of expected {ins, ins_pc}
module tb_fetch_unit;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect_valid = 1'b0;
  logic [13:0] redirect_addr = '0, mem_addr, ins_pc, ras_top;
  logic mem_req, mem_ack = 1'b0, load_IR, ras_push = 1'b0, ras_pop = 1'b0, ras_empty;
  logic [18:0] mem_rdata, ins;
  int checks = 0, errors = 0;
  logic [32:0] q[$];
  logic [32:0] e;
  localparam bit RAS_ON =
`ifdef FETCH_RAS_EN
    1'b1;
`else
    1'b0;
`endif

  function automatic logic [18:0] word(input logic [13:0] a);
    return {a[4:0] ^ 5'h1A, a};
  endfunction

  assign mem_rdata = word(mem_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ins(ins), .load_IR(load_IR),
    .ins_pc(ins_pc), .ras_push(ras_push), .ras_pop(ras_pop),
    .ras_top(ras_top), .ras_empty(ras_empty)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic r, s, rv, input logic [13:0] ra, input logic a, pu, po);
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect_valid = rv; redirect_addr = ra;
    mem_ack = a; ras_push = pu; ras_pop = po;
    @(negedge clk);
  endtask

  task automatic push(input logic [13:0] a);
    q.push_back({word(a), a});
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_IR) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_load got ins_pc=%0h exp=no load", ins_pc);
      end else begin
        e = q.pop_front();
        if ({ins, ins_pc} !== e) begin
          errors++;
          $display("FAIL load_word got=%0h/%0h exp=%0h/%0h", ins, ins_pc, e[32:14], e[13:0]);
        end
      end
    end
  end

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0); push(0);
    chk("rst_req", mem_req, 1); chk("rst_addr", mem_addr, 0); chk("rst_load", load_IR, 0);
    chk("rst_ins", ins, 0); chk("rst_ins_pc", ins_pc, 0);
    chk("rst_ras_empty", ras_empty, 1); chk("rst_ras_top", ras_top, 0);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0); push(14'(k));
      chk("stream_addr", mem_addr, k);
    end
    cyc(0, 1, 0, 0, 1, 0, 0); push(5);
    chk("stall_ack_addr", mem_addr, 5);
    repeat (2) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      chk("hold_req", mem_req, 0); chk("hold_load", load_IR, 0);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("release_load", load_IR, 1); chk("release_ins_pc", ins_pc, 5); chk("release_req", mem_req, 0);
    for (int k = 6; k <= 8; k++) begin
      cyc(0, 0, 0, 0, 1, 0, 0); push(14'(k));
      chk("resume_addr", mem_addr, k); chk("resume_req", mem_req, 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("wait_addr", mem_addr, 9);
    cyc(0, 0, 1, 14'h0100, 1, 0, 0);
    chk("redir_ack_addr", mem_addr, 9); chk("redir_ack_load", load_IR, 0);
    cyc(0, 0, 1, 14'h0200, 0, 0, 0);
    chk("redir_target", mem_addr, 14'h0100); chk("redir_noload", load_IR, 0);
    cyc(0, 0, 1, 14'h3FFF, 0, 0, 0);
    chk("drain_req", mem_req, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    chk("drain_ack_req", mem_req, 0); chk("drain_newest_pc", mem_addr, 14'h3FFF);
    cyc(0, 0, 0, 0, 1, 0, 0); push(14'h3FFF);
    chk("top_addr", mem_addr, 14'h3FFF); chk("top_req", mem_req, 1); chk("drain_noload", load_IR, 0);
    cyc(0, 1, 0, 0, 1, 0, 0);
    chk("wrap_addr", mem_addr, 0); chk("wrap_load", load_IR, 1); chk("wrap_ins_pc", ins_pc, 14'h3FFF);
    cyc(0, 0, 1, 14'h0020, 0, 0, 0);
    chk("hold_redir_load", load_IR, 0); chk("hold_redir_req", mem_req, 0);
    cyc(0, 0, 1, 14'h0040, 0, 0, 0);
    chk("hold_redir_addr", mem_addr, 14'h0020); chk("hold_redir_req2", mem_req, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("drain_before_rst", mem_req, 0);
    cyc(0, 0, 0, 0, 1, 0, 0); push(0);
    chk("rst2_addr", mem_addr, 0); chk("rst2_req", mem_req, 1); chk("rst2_load", load_IR, 0);
    chk("rst2_ins", ins, 0); chk("rst2_ins_pc", ins_pc, 0);
    for (int k = 0; k <= 8; k++) begin
      cyc(0, 0, 0, 0, 1, 1, 0); push(14'(k + 1));
      chk("ras_push_ins_pc", ins_pc, k);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 1);
      chk("ras_pop_top", ras_top, RAS_ON ? 9 - i : 0);
      chk("ras_pop_empty", ras_empty, RAS_ON ? 0 : 1);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    chk("ras_drained_empty", ras_empty, 1); chk("ras_drained_top", ras_top, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("ras_underflow_empty", ras_empty, 1); chk("ras_underflow_top", ras_top, 0);
    cyc(0, 0, 0, 0, 1, 1, 0); push(10);
    chk("ras_ack_addr", mem_addr, 10);
    cyc(0, 0, 0, 0, 0, 1, 1);
    chk("ras_pre_replace", ras_top, RAS_ON ? 10 : 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("ras_replace", ras_top, RAS_ON ? 11 : 0); chk("ras_replace_empty", ras_empty, RAS_ON ? 0 : 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: stall  input  1  decode/IR stage cannot accept a word this cycle.
REQ-004 SHALL have port: redirect_valid  input  1  PC redirect request (JMP/CALL/RET/taken branch).
REQ-005 SHALL have port: redirect_addr  input  14  redirect target.
REQ-006 SHALL have port: mem_req  output  1  instruction-memory read request.
REQ-007 SHALL have port: mem_addr  output  14  read address.
REQ-008 SHALL have port: mem_ack  input  1  read data valid this cycle.
REQ-009 SHALL have port: mem_rdata  input  19  instruction word.
REQ-010 SHALL have port: ins  output  19  fetched word, to instruction register.
REQ-011 SHALL have port: load_IR  output  1  one-cycle strobe: ins valid, IR captures.
REQ-012 SHALL have port: ins_pc  output  14  address of word on ins.
REQ-013 SHALL have ports: ras_push  input  1; ras_pop  input  1; ras_top  output  14; ras_empty  output  1  return-address stack.

Function
REQ-014 SHALL implement FSM states FETCH (request outstanding), DRAIN (outstanding request to discard), HOLD (word captured, downstream stalled).
REQ-015 In FETCH, mem_req SHALL be 1 and mem_addr SHALL equal pc, stable until mem_ack.
REQ-016 On mem_ack in FETCH with stall=0 and no redirect: ins<=mem_rdata, ins_pc<=pc, load_IR=1 next cycle, pc<=pc+1, stay FETCH (one word per cycle at zero wait).
REQ-017 On mem_ack in FETCH with stall=1: capture word, pc<=pc+1, go HOLD; mem_req=0 in HOLD.
REQ-018 In HOLD, load_IR SHALL pulse once in the first cycle stall=0, then return to FETCH.
REQ-019 pc increment SHALL wrap 14'h3FFF -> 14'h0000.
REQ-020 redirect_valid in FETCH without mem_ack: pc<=redirect_addr, go DRAIN; returned word discarded, no load_IR.
REQ-021 redirect_valid with mem_ack same cycle: redirect wins, word discarded, next cycle FETCH at redirect_addr.
REQ-022 redirect_valid in DRAIN: pc updated to newest target; on mem_ack go FETCH.
REQ-023 redirect_valid in HOLD: held word dropped, no load_IR, pc<=redirect_addr, go FETCH.
REQ-024 load_IR SHALL never assert in the cycle redirect_valid is sampled 1.

Reset
REQ-025 rst SHALL force: state FETCH, pc=0, ins=0, ins_pc=0, load_IR=0, RAS empty; mem_req=1, mem_addr=0 first cycle after reset.
REQ-026 rst mid-transaction SHALL abandon outstanding request without load_IR; memory shares rst, so no stale mem_ack follows.

Configuration
REQ-027 Macro FETCH_RAS_EN defined: 8-entry return-address stack; ras_push pushes ins_pc+1 (wrapping); ras_pop removes top; ras_top shows top; push when full overwrites oldest; pop when empty ignored, ras_top=0; push+pop same cycle replaces top.
REQ-028 Macro FETCH_RAS_EN undefined: ports remain; ras_top=0, ras_empty=1, push/pop ignored.

Structure
REQ-029 Shared package cpu_pkg SHALL hold INS_W=19, ADDR_W=14, OPCODE_W=5, RAS_DEPTH=8, and the fetch state enum.
REQ-030 Stack SHALL be sub-module fetch_ras, instantiated only under FETCH_RAS_EN.

Verification
REQ-031 Reset, mem_ack every cycle, stall=0 -> mem_addr 0,1,2,3; load_IR each cycle; ins_pc 0,1,2.
REQ-032 Ack at addr 5 with stall=1 for 3 cycles -> HOLD, mem_req=0, single load_IR with ins_pc=5 after release, next mem_addr=6.
REQ-033 redirect_valid addr 14'h0100 same cycle as ack at addr 9 -> no load_IR for addr 9; next mem_addr=14'h0100.
REQ-034 Redirect to 14'h3FFF, ack -> ins_pc=14'h3FFF, next mem_addr=0.
REQ-035 FETCH_RAS_EN: 9 pushes at ins_pc 0..8 -> ras_top=9; 8 pops return 9..2; 9th pop leaves ras_empty=1, ras_top=0.
REQ-036 rst asserted during DRAIN -> next cycle mem_addr=0, load_IR=0, state FETCH.
